// File: rtl/ibex_pkg.sv
// Shared types for the operand fetch stage: FSM state encoding and the per-source
// resolution helper used by ibex_operand_fetch.
package ibex_pkg;

    typedef enum logic [0:0] {
        OF_IDLE,
        OF_STALL
    } opfetch_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [31:0] data;
        logic        hazard;
    } operand_res_t;

    // Priority: int x0, same-file writeback bypass, pending write, register file.
    function automatic operand_res_t resolve_operand(
        input logic [4:0]  addr,
        input logic        is_fp,
        input logic        wb_we,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data,
        input logic        sb_bit,
        input logic [31:0] rf_data
    );
        operand_res_t res;
        res.data   = rf_data;
        res.hazard = 1'b0;
        if (!is_fp && (addr == REG_X0)) begin
            res.data = '0;
        end else if (wb_we && (wb_addr == addr)) begin
            res.data = wb_data;
        end else if (sb_bit) begin
            res.hazard = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_reg_scoreboard.sv
// Per-register pending-write scoreboard: one bit per architectural register,
// set on issue and cleared on writeback, with set taking priority.
module ibex_reg_scoreboard #(
    parameter bit MaskX0 = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        set_i,
    input  logic [4:0]  set_addr_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_addr_i,
    output logic [31:0] sb_o,
    output logic        any_o
);

    logic [31:0] sb_d, sb_q;
    logic        any_q;

    always_comb begin
        sb_d = sb_q;
        if (clr_i) sb_d[clr_addr_i] = 1'b0;
        if (set_i) sb_d[set_addr_i] = 1'b1;
        if (MaskX0) sb_d[0] = 1'b0;
    end

    // any_q tracks the next state so it stays aligned with sb_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q  <= '0;
            any_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            any_q <= |sb_d;
        end
    end

    assign sb_o  = sb_q;
    assign any_o = any_q;

endmodule

// File: rtl/ibex_operand_fetch.sv
// Operand fetch: reads int/FP register files, tracks pending writes, bypasses writeback
// and presents resolved operands in a valid/ready slot. IBEX_OPFETCH_PERF_EN adds a stall counter.
module ibex_operand_fetch
    import ibex_pkg::*;
#(
    parameter bit RegFileFP = 1'b1,
    parameter bit ResetAll  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        rs1_is_fp_i,
    input  logic        rs2_is_fp_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_we_i,
    input  logic        rd_is_fp_i,
    output logic [4:0]  rf_raddr_a_o,
    input  logic [31:0] rf_rdata_a_i,
    output logic [4:0]  rf_raddr_b_o,
    input  logic [31:0] rf_rdata_b_i,
    output logic [4:0]  rf_fp_raddr_a_o,
    input  logic [31:0] rf_fp_rdata_a_i,
    output logic [4:0]  rf_fp_raddr_b_o,
    input  logic [31:0] rf_fp_rdata_b_i,
    input  logic [4:0]  rf_waddr_wb_i,
    input  logic [31:0] rf_wdata_wb_i,
    input  logic        rf_we_int_wb_i,
    input  logic        rf_we_fp_wb_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic [4:0]  op_rd_o,
    output logic        op_rd_we_o,
    output logic        op_rd_is_fp_o,
    output logic        busy_o
`ifdef IBEX_OPFETCH_PERF_EN
    ,
    output logic [15:0] perf_stall_cycles_o
`endif
);

    opfetch_state_e state_q;
    logic           op_valid_q;
    logic [31:0]    op_a_q, op_b_q;
    logic [4:0]     op_rd_q;
    logic           op_rd_we_q, op_rd_is_fp_q;

    logic           rs1_fp, rs2_fp, rd_fp, we_fp_wb;
    logic [31:0]    int_sb, fp_sb;
    logic           int_any, fp_any;
    operand_res_t   res_a, res_b;
    logic           hazard, slot_free, capture;

    // Without an FP file every FP select collapses onto the integer file.
    assign rs1_fp   = RegFileFP & rs1_is_fp_i;
    assign rs2_fp   = RegFileFP & rs2_is_fp_i;
    assign rd_fp    = RegFileFP & rd_is_fp_i;
    assign we_fp_wb = RegFileFP & rf_we_fp_wb_i;

    assign rf_raddr_a_o    = rs1_addr_i;
    assign rf_raddr_b_o    = rs2_addr_i;
    assign rf_fp_raddr_a_o = RegFileFP ? rs1_addr_i : 5'd0;
    assign rf_fp_raddr_b_o = RegFileFP ? rs2_addr_i : 5'd0;

    always_comb begin
        res_a = resolve_operand(rs1_addr_i, rs1_fp, rs1_fp ? we_fp_wb : rf_we_int_wb_i,
                                rf_waddr_wb_i, rf_wdata_wb_i,
                                rs1_fp ? fp_sb[rs1_addr_i] : int_sb[rs1_addr_i],
                                rs1_fp ? rf_fp_rdata_a_i : rf_rdata_a_i);
        res_b = resolve_operand(rs2_addr_i, rs2_fp, rs2_fp ? we_fp_wb : rf_we_int_wb_i,
                                rf_waddr_wb_i, rf_wdata_wb_i,
                                rs2_fp ? fp_sb[rs2_addr_i] : int_sb[rs2_addr_i],
                                rs2_fp ? rf_fp_rdata_b_i : rf_rdata_b_i);
        hazard        = res_a.hazard | res_b.hazard;
        slot_free     = ~op_valid_q | op_ready_i;
        instr_ready_o = slot_free & ~(instr_valid_i & hazard);
        capture       = instr_valid_i & instr_ready_o;
    end

    // Sources are resolved against sb_q, so an rd that equals a source is not self-blocking.
    ibex_reg_scoreboard #(
        .MaskX0(1'b1)
    ) u_int_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (capture & rd_we_i & ~rd_fp),
        .set_addr_i (rd_addr_i),
        .clr_i      (rf_we_int_wb_i),
        .clr_addr_i (rf_waddr_wb_i),
        .sb_o       (int_sb),
        .any_o      (int_any)
    );

    if (RegFileFP) begin : g_fp_sb
        ibex_reg_scoreboard #(
            .MaskX0(1'b0)
        ) u_fp_sb (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .set_i      (capture & rd_we_i & rd_fp),
            .set_addr_i (rd_addr_i),
            .clr_i      (we_fp_wb),
            .clr_addr_i (rf_waddr_wb_i),
            .sb_o       (fp_sb),
            .any_o      (fp_any)
        );
    end else begin : g_no_fp_sb
        assign fp_sb  = '0;
        assign fp_any = 1'b0;
    end

    assign busy_o = int_any | fp_any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OF_IDLE;
            op_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                OF_IDLE:  if (instr_valid_i && hazard) state_q <= OF_STALL;
                OF_STALL: if (capture || !instr_valid_i) state_q <= OF_IDLE;
                default:  state_q <= OF_IDLE;
            endcase
            if (capture) begin
                op_valid_q <= 1'b1;
            end else if (op_ready_i) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    if (ResetAll) begin : g_data_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                op_a_q        <= '0;
                op_b_q        <= '0;
                op_rd_q       <= '0;
                op_rd_we_q    <= 1'b0;
                op_rd_is_fp_q <= 1'b0;
            end else if (capture) begin
                op_a_q        <= res_a.data;
                op_b_q        <= res_b.data;
                op_rd_q       <= rd_addr_i;
                op_rd_we_q    <= rd_we_i;
                op_rd_is_fp_q <= rd_fp;
            end
        end
    end else begin : g_data_nort
        always_ff @(posedge clk_i) begin
            if (capture) begin
                op_a_q        <= res_a.data;
                op_b_q        <= res_b.data;
                op_rd_q       <= rd_addr_i;
                op_rd_we_q    <= rd_we_i;
                op_rd_is_fp_q <= rd_fp;
            end
        end
    end

    assign op_valid_o    = op_valid_q;
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign op_rd_o       = op_rd_q;
    assign op_rd_we_o    = op_rd_we_q;
    assign op_rd_is_fp_o = op_rd_is_fp_q;

`ifdef IBEX_OPFETCH_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if ((state_q == OF_STALL) && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cycles_o = perf_q;
`endif

endmodule
